// File: rtl/alu_rtl_if.sv
// alu_rtl_if: operand/command/result bundle for alu_rtl
// Parameters: N1 operand width, N2 command width, N3 result width.
// master drives OPA, OPB, CIN, CE, MODE, IN_VALID, CMD and receives RES, COUT, OFLOW, G, E, L, ERR.
// slave is the ALU side with the opposite directions.
interface alu_rtl_if #(parameter int N1 = 8, parameter int N2 = 4, parameter int N3 = 9);
    logic [N1-1:0] OPA, OPB;
    logic          CIN, CE, MODE;
    logic [1:0]    IN_VALID;
    logic [N2-1:0] CMD;
    logic [N3-1:0] RES;
    logic          COUT, OFLOW, G, E, L, ERR;
    modport master (output OPA, OPB, CIN, CE, MODE, IN_VALID, CMD,
                    input RES, COUT, OFLOW, G, E, L, ERR);
    modport slave (input OPA, OPB, CIN, CE, MODE, IN_VALID, CMD,
                   output RES, COUT, OFLOW, G, E, L, ERR);
endinterface

// File: rtl/alu_rtl.sv
// alu_rtl: registered parameterised integer ALU with arithmetic/logical command sets
// Ports: CLK clock; RST synchronous active-high reset (priority over CE);
//   bus (alu_rtl_if.slave): OPA/OPB operands, CIN carry/borrow in, CE clock enable,
//   MODE 1=arith 0=logic, IN_VALID operand valids, CMD command,
//   RES result, COUT carry, OFLOW borrow/signed overflow, G/E/L compare, ERR error.
// Define MUL_EN to enable the 2-cycle MUL_INC/MUL_SHIFT commands (otherwise they flag ERR).
module alu_rtl #(parameter int N1 = 8, parameter int N2 = 4, parameter int N3 = 9) (
    input logic   CLK,
    input logic   RST,
    alu_rtl_if.slave bus
);
    localparam int SW = $clog2(N1);
    logic [31:0]   c;
    logic          mode;
    logic [1:0]    vin;
    logic [N3-1:0] a_z, b_z, a_s, b_s, r;
    logic [N1-1:0] lr, rol, ror;
    logic [SW-1:0] amt;
    logic          rot_bad, need_a, need_b, ok, mul_cmd, bad_cmd;
    logic          co, of, g, e, l, er;
    logic [N3+5:0] nxt;
`ifdef MUL_EN
    logic [N3-1:0] mul_p, mul_q;
    logic          busy;
`endif
    always_comb begin
        c = 32'(bus.CMD);
        mode = bus.MODE;
        vin = bus.IN_VALID;
        a_z = N3'(bus.OPA);
        b_z = N3'(bus.OPB);
        a_s = {{(N3-N1){bus.OPA[N1-1]}}, bus.OPA};
        b_s = {{(N3-N1){bus.OPB[N1-1]}}, bus.OPB};
        amt = bus.OPB[SW-1:0];
        // Amount bits above the field are illegal but the rotate still uses the low bits.
        rot_bad = |(bus.OPB >> SW);
        rol = (bus.OPA << amt) | (bus.OPA >> (N1 - int'(amt)));
        ror = (bus.OPA >> amt) | (bus.OPA << (N1 - int'(amt)));
        need_a = mode ? (c == 4 || c == 5) : (c == 6 || c == 8 || c == 9);
        need_b = mode ? (c == 6 || c == 7) : (c == 7 || c == 10 || c == 11);
        ok = need_a ? vin[0] : need_b ? vin[1] : vin == 2'b11;
        mul_cmd = mode && (c == 9 || c == 10);
`ifdef MUL_EN
        bad_cmd = mode ? c > 12 : c > 13;
        mul_p = (c == 9) ? (a_z + N3'(1)) * (b_z + N3'(1)) : (a_z << 1) * b_z;
`else
        bad_cmd = mode ? (c > 12 || mul_cmd) : c > 13;
`endif
        r = '0;
        lr = '0;
        co = 1'b0;
        of = 1'b0;
        g = 1'b0;
        e = 1'b0;
        l = 1'b0;
        er = 1'b0;
        if (bad_cmd || !ok) begin
            er = 1'b1;
        end else if (mode) begin
            case (c)
                0: begin r = a_z + b_z; co = r[N1]; end
                1: begin r = a_z - b_z; of = a_z < b_z; end
                2: begin r = a_z + b_z + N3'(bus.CIN); co = r[N1]; end
                3: begin r = a_z - b_z - N3'(bus.CIN); of = a_z < b_z + N3'(bus.CIN); end
                4: begin r = a_z + N3'(1); co = r[N1]; end
                5: begin r = a_z - N3'(1); of = a_z == '0; end
                6: begin r = b_z + N3'(1); co = r[N1]; end
                7: begin r = b_z - N3'(1); of = b_z == '0; end
                8: begin g = a_z > b_z; e = a_z == b_z; l = a_z < b_z; end
                // Exact result fits in N1+1 bits, so overflow at N1 bits is a sign mismatch there.
                11: begin r = a_s + b_s; of = r[N1] ^ r[N1-1]; end
                12: begin r = a_s - b_s; of = r[N1] ^ r[N1-1]; end
                default: r = '0;
            endcase
        end else begin
            case (c)
                0: lr = bus.OPA & bus.OPB;
                1: lr = ~(bus.OPA & bus.OPB);
                2: lr = bus.OPA | bus.OPB;
                3: lr = ~(bus.OPA | bus.OPB);
                4: lr = bus.OPA ^ bus.OPB;
                5: lr = ~(bus.OPA ^ bus.OPB);
                6: lr = ~bus.OPA;
                7: lr = ~bus.OPB;
                8: lr = bus.OPA >> 1;
                9: lr = bus.OPA << 1;
                10: lr = bus.OPB >> 1;
                11: lr = bus.OPB << 1;
                12: begin lr = rol; er = rot_bad; end
                13: begin lr = ror; er = rot_bad; end
                default: lr = '0;
            endcase
            r = N3'(lr);
        end
        nxt = {r, co, of, g, e, l, er};
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            {bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR} <= '0;
`ifdef MUL_EN
            busy <= 1'b0;
            mul_q <= '0;
`endif
        end else if (bus.CE) begin
`ifdef MUL_EN
            // Second cycle of a multiply: deliver the product and ignore whatever is on the inputs.
            if (busy) begin
                {bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR} <= {mul_q, 6'b0};
                busy <= 1'b0;
            end else if (mul_cmd && !bad_cmd && ok) begin
                mul_q <= mul_p;
                busy <= 1'b1;
            end else begin
                {bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR} <= nxt;
            end
`else
            {bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR} <= nxt;
`endif
        end
    end
endmodule

// File: tb/tb_alu_rtl.sv
// tb_alu_rtl: directed self-checking bench for alu_rtl
module tb_alu_rtl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    logic [14:0] obs;
    typedef struct {
        logic mode;
        logic [3:0] cmd;
        logic [7:0] a, b;
        logic cin;
        logic [1:0] vin;
        logic [14:0] exp;
    } vec_t;

    alu_rtl_if #(.N1(8), .N2(4), .N3(9)) bus();
    alu_rtl #(.N1(8), .N2(4), .N3(9)) dut (.CLK(clk), .RST(rst), .bus(bus.slave));

    always #5 clk = ~clk;
    // {RES, COUT, OFLOW, G, E, L, ERR}
    assign obs = {bus.RES, bus.COUT, bus.OFLOW, bus.G, bus.E, bus.L, bus.ERR};

    task automatic drive(input logic ce, input logic mode, input logic [3:0] cmd,
                         input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [1:0] vin);
        @(negedge clk);
        bus.CE = ce;
        bus.MODE = mode;
        bus.CMD = cmd;
        bus.OPA = a;
        bus.OPB = b;
        bus.CIN = cin;
        bus.IN_VALID = vin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'd0, 8'd10, 8'd10, 1'b0, 2'b11);
        total++;
        if (obs !== 15'd0) begin bad++; $display("FAIL reset got=%h exp=%h", obs, 15'd0); end
        rst = 1'b0;
        drive(1'b1, 1'b1, 4'd0, 8'd10, 8'd10, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd20, 6'b0}) begin bad++; $display("FAIL pre_rst got=%h exp=%h", obs, {9'd20, 6'b0}); end
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'd0, 8'd10, 8'd10, 1'b0, 2'b11);
        total++;
        if (obs !== 15'd0) begin bad++; $display("FAIL mid_rst got=%h exp=%h", obs, 15'd0); end
        rst = 1'b0;
    endtask

    task automatic test_arith;
        vec_t t[17] = '{
            '{1'b1, 4'd0, 8'd10, 8'd10, 1'b0, 2'b11, {9'd20, 6'b000000}},
            '{1'b1, 4'd1, 8'd50, 8'd25, 1'b0, 2'b11, {9'd25, 6'b000000}},
            '{1'b1, 4'd2, 8'd5, 8'd10, 1'b1, 2'b11, {9'd16, 6'b000000}},
            '{1'b1, 4'd3, 8'd20, 8'd10, 1'b1, 2'b11, {9'd9, 6'b000000}},
            '{1'b1, 4'd6, 8'd0, 8'd255, 1'b0, 2'b10, {9'd256, 6'b100000}},
            '{1'b1, 4'd7, 8'd0, 8'd0, 1'b0, 2'b10, {9'd511, 6'b010000}},
            '{1'b1, 4'd5, 8'd9, 8'd0, 1'b0, 2'b10, {9'd0, 6'b000001}},
            '{1'b1, 4'd4, 8'd255, 8'd0, 1'b0, 2'b01, {9'd256, 6'b100000}},
            '{1'b1, 4'd8, 8'd20, 8'd20, 1'b0, 2'b11, {9'd0, 6'b000100}},
            '{1'b1, 4'd8, 8'd30, 8'd20, 1'b0, 2'b11, {9'd0, 6'b001000}},
            '{1'b1, 4'd8, 8'd10, 8'd20, 1'b0, 2'b11, {9'd0, 6'b000010}},
            '{1'b1, 4'd11, 8'hCE, 8'd20, 1'b0, 2'b11, {9'd482, 6'b000000}},
            '{1'b1, 4'd12, 8'hF6, 8'd20, 1'b0, 2'b11, {9'd482, 6'b000000}},
            '{1'b1, 4'd11, 8'd100, 8'd100, 1'b0, 2'b11, {9'd200, 6'b010000}},
            '{1'b1, 4'd1, 8'd5, 8'd10, 1'b0, 2'b11, {9'd507, 6'b010000}},
            '{1'b1, 4'd13, 8'd1, 8'd1, 1'b0, 2'b11, {9'd0, 6'b000001}},
            '{1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b01, {9'd0, 6'b000001}}
        };
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, t[i].mode, t[i].cmd, t[i].a, t[i].b, t[i].cin, t[i].vin);
            total++;
            if (obs !== t[i].exp) begin bad++; $display("FAIL arith[%0d] got=%h exp=%h", i, obs, t[i].exp); end
        end
    endtask

    task automatic test_logic;
        vec_t t[17] = '{
            '{1'b0, 4'd0, 8'hAA, 8'hF0, 1'b0, 2'b11, {9'h0A0, 6'b0}},
            '{1'b0, 4'd1, 8'hAA, 8'hF0, 1'b0, 2'b11, {9'h05F, 6'b0}},
            '{1'b0, 4'd2, 8'hAA, 8'hF0, 1'b0, 2'b11, {9'h0FA, 6'b0}},
            '{1'b0, 4'd3, 8'hAA, 8'hF0, 1'b0, 2'b11, {9'h005, 6'b0}},
            '{1'b0, 4'd4, 8'hAA, 8'hF0, 1'b0, 2'b11, {9'h05A, 6'b0}},
            '{1'b0, 4'd5, 8'hAA, 8'hF0, 1'b0, 2'b11, {9'h0A5, 6'b0}},
            '{1'b0, 4'd6, 8'h55, 8'h00, 1'b0, 2'b01, {9'h0AA, 6'b0}},
            '{1'b0, 4'd7, 8'h00, 8'hF0, 1'b0, 2'b10, {9'h00F, 6'b0}},
            '{1'b0, 4'd8, 8'hAA, 8'h00, 1'b0, 2'b01, {9'h055, 6'b0}},
            '{1'b0, 4'd9, 8'h01, 8'h00, 1'b0, 2'b01, {9'h002, 6'b0}},
            '{1'b0, 4'd10, 8'h00, 8'hF0, 1'b0, 2'b10, {9'h078, 6'b0}},
            '{1'b0, 4'd11, 8'h00, 8'hF0, 1'b0, 2'b10, {9'h0E0, 6'b0}},
            '{1'b0, 4'd12, 8'hF0, 8'h01, 1'b0, 2'b11, {9'h0E1, 6'b0}},
            '{1'b0, 4'd13, 8'hF0, 8'h02, 1'b0, 2'b11, {9'h03C, 6'b0}},
            '{1'b0, 4'd12, 8'hF0, 8'hFF, 1'b0, 2'b11, {9'h078, 6'b000001}},
            '{1'b0, 4'd14, 8'hAA, 8'hF0, 1'b0, 2'b11, {9'h000, 6'b000001}},
            '{1'b0, 4'd6, 8'h55, 8'h00, 1'b0, 2'b10, {9'h000, 6'b000001}}
        };
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, t[i].mode, t[i].cmd, t[i].a, t[i].b, t[i].cin, t[i].vin);
            total++;
            if (obs !== t[i].exp) begin bad++; $display("FAIL logic[%0d] got=%h exp=%h", i, obs, t[i].exp); end
        end
    endtask

    task automatic test_ce;
        drive(1'b1, 1'b1, 4'd0, 8'd10, 8'd10, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd20, 6'b0}) begin bad++; $display("FAIL ce_load got=%h exp=%h", obs, {9'd20, 6'b0}); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 4'd7, 8'd0, 8'd0, 1'b0, 2'b10);
            total++;
            if (obs !== {9'd20, 6'b0}) begin bad++; $display("FAIL ce_hold[%0d] got=%h exp=%h", i, obs, {9'd20, 6'b0}); end
        end
        drive(1'b1, 1'b1, 4'd1, 8'd50, 8'd25, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd25, 6'b0}) begin bad++; $display("FAIL ce_resume got=%h exp=%h", obs, {9'd25, 6'b0}); end
    endtask

    task automatic test_mul;
`ifdef MUL_EN
        drive(1'b1, 1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b11);
        drive(1'b1, 1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd2, 6'b0}) begin bad++; $display("FAIL mul_issue got=%h exp=%h", obs, {9'd2, 6'b0}); end
        drive(1'b1, 1'b1, 4'd0, 8'd7, 8'd7, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd20, 6'b0}) begin bad++; $display("FAIL mul_inc got=%h exp=%h", obs, {9'd20, 6'b0}); end
        drive(1'b1, 1'b1, 4'd10, 8'd3, 8'd4, 1'b0, 2'b11);
        drive(1'b0, 1'b1, 4'd0, 8'd7, 8'd7, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd20, 6'b0}) begin bad++; $display("FAIL mul_ce_hold got=%h exp=%h", obs, {9'd20, 6'b0}); end
        drive(1'b1, 1'b1, 4'd0, 8'd7, 8'd7, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd24, 6'b0}) begin bad++; $display("FAIL mul_shift got=%h exp=%h", obs, {9'd24, 6'b0}); end
        drive(1'b1, 1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11);
        rst = 1'b1;
        drive(1'b1, 1'b1, 4'd0, 8'd7, 8'd7, 1'b0, 2'b11);
        rst = 1'b0;
        drive(1'b1, 1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd2, 6'b0}) begin bad++; $display("FAIL mul_flush got=%h exp=%h", obs, {9'd2, 6'b0}); end
`else
        drive(1'b1, 1'b1, 4'd0, 8'd1, 8'd1, 1'b0, 2'b11);
        drive(1'b1, 1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd0, 6'b000001}) begin bad++; $display("FAIL mul_inc_off got=%h exp=%h", obs, {9'd0, 6'b000001}); end
        drive(1'b1, 1'b1, 4'd10, 8'd3, 8'd4, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd0, 6'b000001}) begin bad++; $display("FAIL mul_shift_off got=%h exp=%h", obs, {9'd0, 6'b000001}); end
`endif
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 1'b1, 4'd8, 8'd30, 8'd20, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd0, 6'b001000}) begin bad++; $display("FAIL b2b_cmp got=%h exp=%h", obs, {9'd0, 6'b001000}); end
        drive(1'b1, 1'b1, 4'd0, 8'd255, 8'd255, 1'b0, 2'b11);
        total++;
        if (obs !== {9'd510, 6'b100000}) begin bad++; $display("FAIL b2b_add got=%h exp=%h", obs, {9'd510, 6'b100000}); end
        drive(1'b1, 1'b0, 4'd4, 8'hAA, 8'hF0, 1'b0, 2'b11);
        total++;
        if (obs !== {9'h05A, 6'b0}) begin bad++; $display("FAIL b2b_xor got=%h exp=%h", obs, {9'h05A, 6'b0}); end
    endtask

    initial begin
        bus.CE = 1'b0;
        bus.MODE = 1'b0;
        bus.CMD = '0;
        bus.OPA = '0;
        bus.OPB = '0;
        bus.CIN = 1'b0;
        bus.IN_VALID = 2'b00;
        test_reset;
        test_arith;
        test_logic;
        test_ce;
        test_mul;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
